// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter.
//   NREQ  : number of requesters
//   SEL_W : width of the requester index
//   arb_state_e : arbiter FSM states
package mux_arb_pkg;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;
endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin priority picker.
//   req : request mask to choose from
//   ptr : highest-priority index; search order ptr, ptr+1, ptr+2, ptr+3 (mod 4)
//   win : one-hot winner (zero when no request)
//   idx : winner index (zero when no request)
//   any : at least one request present
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [NREQ-1:0]  win,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [SEL_W-1:0] cand;

  // First set bit at or after ptr, wrapping modulo NREQ.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = ptr + SEL_W'(i);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

  assign win = any ? (NREQ'(1) << idx) : '0;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Four-requester round-robin arbiter with hold limit and output data mux.
//   clk, rst_n   : clock, asynchronous active-low reset
//   req          : per-requester level requests
//   d0..d3       : requester data words
//   gnt          : registered one-hot grant (zero when idle)
//   sel          : registered index of current/last granted requester
//   out_valid    : granted requester still requesting (combinational)
//   data_out     : selected data word, zero when out_valid is low (combinational)
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned W        = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [W-1:0]     d0,
  input  logic [W-1:0]     d1,
  input  logic [W-1:0]     d2,
  input  logic [W-1:0]     d3,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic             out_valid,
  output logic [W-1:0]     data_out
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_e       state, state_d;
  logic [NREQ-1:0]  gnt_d;
  logic [SEL_W-1:0] sel_d;
  logic [SEL_W-1:0] ptr, ptr_d;
  logic [CNT_W-1:0] cnt, cnt_d;

  logic [NREQ-1:0]  pick_mask;
  logic [NREQ-1:0]  win_oh;
  logic [SEL_W-1:0] win_idx;
  logic             win_any;
  logic             hold_req;

  assign hold_req = |(gnt & req);

  // While granted, the current holder is excluded from the pick; it only
  // matters when the holder releases (bit already low) or is preempted.
  assign pick_mask = (state == IDLE) ? req : (req & ~gnt);

  rr_pick4 u_pick (
    .req (pick_mask),
    .ptr (ptr),
    .win (win_oh),
    .idx (win_idx),
    .any (win_any)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      gnt   <= gnt_d;
      sel   <= sel_d;
      ptr   <= ptr_d;
      cnt   <= cnt_d;
    end
  end

  // Next-state logic: new grants take the picker winner and restart the hold count
  always_comb begin
    state_d = state;
    gnt_d   = gnt;
    sel_d   = sel;
    ptr_d   = ptr;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (win_any) begin
          state_d = GRANT;
          gnt_d   = win_oh;
          sel_d   = win_idx;
          ptr_d   = win_idx + SEL_W'(1);
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (!hold_req || (cnt == HOLD_LAST)) begin
          if (win_any) begin
            gnt_d = win_oh;
            sel_d = win_idx;
            ptr_d = win_idx + SEL_W'(1);
            cnt_d = '0;
          end else if (!hold_req) begin
            state_d = IDLE;
            gnt_d   = '0;
          end else begin
            // Hold limit reached with nobody waiting: keep the grant.
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  assign out_valid = hold_req;

  // 4:1 data select on sel, gated by out_valid
  always_comb begin
    data_out = '0;
    if (out_valid) begin
      case (sel)
        2'd0:    data_out = d0;
        2'd1:    data_out = d1;
        2'd2:    data_out = d2;
        default: data_out = d3;
      endcase
    end
  end

endmodule
